// File: rtl/multicycle_divider_pkg.sv
// Shared definitions for the EXE-stage divider.
//   - DIV_WIDTH: datapath width, shared with the HI/LO registers and the
//     pipeline controller.
//   - div_state_e: divider FSM encoding (IDLE, CALC, DONE).
//   - cond_negate / magnitude: two's-complement helpers, also reused by the
//     multiplier. Negation wraps modulo 2^DIV_WIDTH, so the magnitude of the
//     most negative value is returned as the unsigned value 2^(DIV_WIDTH-1).
package multicycle_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  function automatic logic [DIV_WIDTH-1:0] cond_negate(
    input logic [DIV_WIDTH-1:0] val,
    input logic                 neg
  );
    return neg ? (~val + DIV_WIDTH'(1)) : val;
  endfunction

  function automatic logic [DIV_WIDTH-1:0] magnitude(
    input logic [DIV_WIDTH-1:0] val,
    input logic                 is_signed
  );
    return cond_negate(val, is_signed & val[DIV_WIDTH-1]);
  endfunction

endpackage

// File: rtl/multicycle_divider.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EXE stage.
// LO receives the quotient and HI receives the remainder.
//
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   i_start        : divide request, held while the instruction sits in EXE
//   i_signed       : 1 = DIV, 0 = DIVU (sampled with i_start)
//   i_dividend     : rs operand
//   i_divisor      : rt operand
//   i_cancel       : MEM exception flush; aborts any operation
//   o_busy         : stall request (start cycle plus every CALC cycle)
//   o_done         : one-cycle pulse in DONE; results valid this cycle
//   o_quotient     : LO value
//   o_remainder    : HI value
//   o_div_by_zero  : divisor-was-zero flag for the last result
//   o_state        : current FSM state (debug visibility)
//
// Result timing: during the DONE cycle the final result is formed from the
// datapath registers and driven onto the outputs together with o_done; at the
// end of that cycle it is committed to the output registers, which then hold
// it. A cancel in DONE suppresses both o_done and the commit, so the outputs
// keep the previous result.
//
// Handshake: i_start is a level request, not a valid/ready transfer. A start
// is accepted only in IDLE when i_cancel is low; i_start is ignored in CALC
// and DONE, so an instruction held in EXE through DONE does not restart.
module multicycle_divider
  import multicycle_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero,
  output logic [1:0]       o_state
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Partial remainder never exceeds the divisor, so WIDTH bits of storage
  // suffice; the shift/trial-subtract works on WIDTH+1 bits.
  logic [WIDTH-1:0] rem_q, rem_d;
  // Dividend shift register; quotient bits shift in from the right.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] raw_dvd_q, raw_dvd_d;
  logic             quot_neg_q, quot_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic             accept;
  logic             commit;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] res_quot;
  logic [WIDTH-1:0] res_rem;

  assign accept = (state_q == ST_IDLE) & i_start & ~i_cancel;
  assign commit = (state_q == ST_DONE) & ~i_cancel;

  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr_q};

  // Divide by zero overrides the datapath result.
  assign res_quot = dbz_q ? {WIDTH{1'b1}} : cond_negate(dvd_q, quot_neg_q);
  assign res_rem  = dbz_q ? raw_dvd_q     : cond_negate(rem_q, rem_neg_q);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    dvd_d         = dvd_q;
    dsr_d         = dsr_q;
    raw_dvd_d     = raw_dvd_q;
    quot_neg_d    = quot_neg_q;
    rem_neg_d     = rem_neg_q;
    dbz_d         = dbz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    o_busy        = 1'b0;
    o_done        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          o_busy     = 1'b1;
          dvd_d      = magnitude(i_dividend, i_signed);
          dsr_d      = magnitude(i_divisor, i_signed);
          quot_neg_d = i_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
          rem_neg_d  = i_signed & i_dividend[WIDTH-1];
          raw_dvd_d  = i_dividend;
          dbz_d      = (i_divisor == '0);
          rem_d      = '0;
          cnt_d      = CNT_W'(WIDTH);
          state_d    = ST_CALC;
        end
      end

      ST_CALC: begin
        o_busy = 1'b1;
        if (i_cancel) begin
          state_d = ST_IDLE;
        end else begin
          // Non-negative trial result: keep it and shift in a 1.
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (commit) begin
          o_done        = 1'b1;
          quotient_d    = res_quot;
          remainder_d   = res_rem;
          div_by_zero_d = dbz_q;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      dvd_q         <= '0;
      dsr_q         <= '0;
      raw_dvd_q     <= '0;
      quot_neg_q    <= 1'b0;
      rem_neg_q     <= 1'b0;
      dbz_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      dvd_q         <= dvd_d;
      dsr_q         <= dsr_d;
      raw_dvd_q     <= raw_dvd_d;
      quot_neg_q    <= quot_neg_d;
      rem_neg_q     <= rem_neg_d;
      dbz_q         <= dbz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  // In DONE the outputs show the result being committed this cycle.
  assign o_quotient    = commit ? res_quot : quotient_q;
  assign o_remainder   = commit ? res_rem  : remainder_q;
  assign o_div_by_zero = commit ? dbz_q    : div_by_zero_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_multicycle_divider.sv
module tb_multicycle_divider;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] CALC_ENC = 2'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        dbz;
  logic [1:0]  state;

  int total = 0;
  int bad = 0;

  multicycle_divider dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (start),
    .i_signed      (sgn),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .i_cancel      (cancel),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (dbz),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a divide with i_start held until o_done, then drop i_start on the
  // edge that leaves DONE and check the following cycle.
  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_q,
                         input logic [31:0] exp_r, input logic exp_z);
    int  busy_cnt;
    int  cyc;
    bit  done_seen;
    busy_cnt  = 0;
    cyc       = 0;
    done_seen = 0;
    start     = 1'b1;
    sgn       = s;
    dividend  = a;
    divisor   = b;
    #3;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    while (!done_seen && cyc < 100) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_seen = 1;
        check({tag, "_q"}, quotient, exp_q);
        check({tag, "_r"}, remainder, exp_r);
        check({tag, "_dbz"}, 32'(dbz), 32'(exp_z));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      end else begin
        @(posedge clk);
        #4;
        cyc++;
      end
    end
    check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    tick();
    start = 1'b0;
    #3;
    check({tag, "_after_busy"}, 32'(busy), 32'd0);
    check({tag, "_after_done"}, 32'(done), 32'd0);
    check({tag, "_after_state"}, 32'(state), 32'(IDLE_ENC));
    check({tag, "_hold_q"}, quotient, exp_q);
    check({tag, "_hold_r"}, remainder, exp_r);
  endtask

  initial begin
    int done_hits;

    // Reset state
    tick();
    tick();
    #3;
    check("rst_state", 32'(state), 32'(IDLE_ENC));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dbz", 32'(dbz), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Unsigned and signed divides
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    tick();
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    tick();
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    tick();
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    tick();
    run_div("divu_by0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    tick();
    run_div("div_by0", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    tick();
    run_div("divu_max", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1'b0);
    tick();
    run_div("divu_small", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0);

    // Cancel at CALC cycle 10; prior result 0/5 must remain
    tick();
    start    = 1'b1;
    sgn      = 1'b0;
    dividend = 32'd1000;
    divisor  = 32'd3;
    for (int i = 0; i < 10; i++) tick();
    #3;
    check("cancel_pre_state", 32'(state), 32'(CALC_ENC));
    #1;
    cancel = 1'b1;
    start  = 1'b0;
    tick();
    cancel = 1'b0;
    #3;
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_state", 32'(state), 32'(IDLE_ENC));
    check("cancel_done", 32'(done), 32'd0);
    done_hits = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_hits++;
    end
    check("cancel_no_done", 32'(done_hits), 32'd0);
    check("cancel_hold_q", quotient, 32'd0);
    check("cancel_hold_r", remainder, 32'd5);

    // Start and cancel in the same IDLE cycle
    start    = 1'b1;
    cancel   = 1'b1;
    dividend = 32'd77;
    divisor  = 32'd7;
    #3;
    check("sc_busy", 32'(busy), 32'd0);
    tick();
    start  = 1'b0;
    cancel = 1'b0;
    #3;
    check("sc_state", 32'(state), 32'(IDLE_ENC));
    check("sc_busy_next", 32'(busy), 32'd0);

    // Reset at CALC cycle 5
    tick();
    run_div("divu_pre_rst", 1'b0, 32'd50, 32'd6, 32'd8, 32'd2, 1'b0);
    tick();
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    start = 1'b0;
    tick();
    #3;
    check("mrst_state", 32'(state), 32'(IDLE_ENC));
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_q", quotient, 32'd0);
    check("mrst_r", remainder, 32'd0);
    check("mrst_dbz", 32'(dbz), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_div("divu_post_rst", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
